writeback_stage: RTL and testbench

Final pipeline stage; sole driver of the register file's single write port (wr_en_i / wr_addr_i / data_i).

---
 rtl/writeback_stage.sv | 157 +++++++++++++++
 tb/tb_writeback_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: sole driver of the register-file write port.
// Loads bypass everything; ALU results queue in a small in-order FIFO and
// flow straight through when nothing else is waiting. Writes to r15 become
// a PC redirect instead of a register write.
// Optional operand forwarding lookup is enabled with `define WB_FWD_EN.
module writeback_stage #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CW    = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          alu_valid_i,
   output logic          alu_ready_o,
   input  logic [3:0]    alu_addr_i,
   input  logic [31:0]   alu_data_i,
   input  logic          mem_valid_i,
   input  logic [3:0]    mem_addr_i,
   input  logic [31:0]   mem_data_i,
   output logic          wr_en_o,
   output logic [3:0]    wr_addr_o,
   output logic [31:0]   wr_data_o,
   output logic          pc_wr_en_o,
   output logic [31:0]   pc_wr_data_o,
`ifdef WB_FWD_EN
   input  logic [3:0]    q1_addr_i,
   input  logic [3:0]    q2_addr_i,
   output logic          q1_hit_o,
   output logic          q2_hit_o,
   output logic [31:0]   q1_data_o,
   output logic [31:0]   q2_data_o,
`endif
   output logic [CW-1:0] pending_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  PcAddr = 4'hF;

   logic [3:0]    fifo_addr_q [DEPTH];
   logic [31:0]   fifo_data_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          wr_en_q, wr_en_d;
   logic [3:0]    wr_addr_q, wr_addr_d;
   logic [31:0]   wr_data_q, wr_data_d;
   logic          pc_wr_en_q, pc_wr_en_d;
   logic [31:0]   pc_wr_data_q, pc_wr_data_d;

   logic          empty, full, push, sel_pop, sel_flow, fifo_wr, sel_valid;
   logic [3:0]    sel_addr;
   logic [31:0]   sel_data;

   // Source selection and FIFO bookkeeping; ready depends on count only.
   always_comb begin
      empty       = (count_q == '0);
      full        = (count_q == CW'(DEPTH));
      alu_ready_o = !full;
      push        = alu_valid_i && !full;
      sel_pop     = !mem_valid_i && !empty;
      sel_flow    = !mem_valid_i && empty && push;
      fifo_wr     = push && !sel_flow;
      sel_valid   = mem_valid_i || !empty || push;
      sel_addr    = alu_addr_i;
      sel_data    = alu_data_i;
      if (mem_valid_i) begin
         sel_addr = mem_addr_i;
         sel_data = mem_data_i;
      end else if (!empty) begin
         sel_addr = fifo_addr_q[rptr_q];
         sel_data = fifo_data_q[rptr_q];
      end
      wptr_d  = fifo_wr ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = sel_pop ? rptr_q + PW'(1) : rptr_q;
      count_d = count_q + CW'(fifo_wr) - CW'(sel_pop);
   end

   // Output register next state; address/data hold when nothing is written.
   always_comb begin
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      pc_wr_en_d   = 1'b0;
      pc_wr_data_d = pc_wr_data_q;
      if (sel_valid) begin
         if (sel_addr == PcAddr) begin
            pc_wr_en_d   = 1'b1;
            pc_wr_data_d = sel_data;
         end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
         end
      end
   end

   // Control state and output registers, cleared asynchronously.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         pc_wr_en_q   <= 1'b0;
         pc_wr_data_q <= '0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         pc_wr_en_q   <= pc_wr_en_d;
         pc_wr_data_q <= pc_wr_data_d;
      end
   end

   // FIFO storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk_i) begin
      if (fifo_wr) begin
         fifo_addr_q[wptr_q] <= alu_addr_i;
         fifo_data_q[wptr_q] <= alu_data_i;
      end
   end

   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign pc_wr_en_o   = pc_wr_en_q;
   assign pc_wr_data_o = pc_wr_data_q;
   assign pending_o    = count_q;

`ifdef WB_FWD_EN
   // Returns {hit, data}: output register first, then FIFO oldest to
   // youngest so the youngest match wins. r15 never hits.
   function automatic logic [32:0] fwd_lookup(input logic [3:0] a);
      logic [32:0] r;
      r = '0;
      if (wr_en_q && wr_addr_q == a) r = {1'b1, wr_data_q};
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count_q && fifo_addr_q[rptr_q + PW'(i)] == a) begin
            r = {1'b1, fifo_data_q[rptr_q + PW'(i)]};
         end
      end
      if (a == PcAddr) r = '0;
      return r;
   endfunction

   // Combinational forwarding lookups for two read operands.
   always_comb begin
      {q1_hit_o, q1_data_o} = fwd_lookup(q1_addr_i);
      {q2_hit_o, q2_data_o} = fwd_lookup(q2_addr_i);
   end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage (DEPTH=2): directed vector table,
// reset and forwarding sequences, then random traffic against a queue model.
module tb_writeback_stage;

   localparam int DEPTH = 2;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        alu_valid_i, alu_ready_o;
   logic [3:0]  alu_addr_i;
   logic [31:0] alu_data_i;
   logic        mem_valid_i;
   logic [3:0]  mem_addr_i;
   logic [31:0] mem_data_i;
   logic        wr_en_o, pc_wr_en_o;
   logic [3:0]  wr_addr_o;
   logic [31:0] wr_data_o, pc_wr_data_o;
   logic [1:0]  pending_o;
`ifdef WB_FWD_EN
   logic [3:0]  q1_addr_i, q2_addr_i;
   logic        q1_hit_o, q2_hit_o;
   logic [31:0] q1_data_o, q2_data_o;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   writeback_stage #(.DEPTH(2), .CW(2)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .alu_valid_i  (alu_valid_i),
      .alu_ready_o  (alu_ready_o),
      .alu_addr_i   (alu_addr_i),
      .alu_data_i   (alu_data_i),
      .mem_valid_i  (mem_valid_i),
      .mem_addr_i   (mem_addr_i),
      .mem_data_i   (mem_data_i),
      .wr_en_o      (wr_en_o),
      .wr_addr_o    (wr_addr_o),
      .wr_data_o    (wr_data_o),
      .pc_wr_en_o   (pc_wr_en_o),
      .pc_wr_data_o (pc_wr_data_o),
`ifdef WB_FWD_EN
      .q1_addr_i    (q1_addr_i),
      .q2_addr_i    (q2_addr_i),
      .q1_hit_o     (q1_hit_o),
      .q2_hit_o     (q2_hit_o),
      .q1_data_o    (q1_data_o),
      .q2_data_o    (q2_data_o),
`endif
      .pending_o    (pending_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        mv; logic [3:0] ma; logic [31:0] md;
      logic        av; logic [3:0] aa; logic [31:0] ad;
      logic        wr_en; logic [3:0] wa; logic [31:0] wd; logic chk_wd;
      logic        pc_en; logic [31:0] pd;
      logic [1:0]  pend; logic rdy;
   } vec_t;

   typedef struct { logic [3:0] a; logic [31:0] d; } ent_t;

   vec_t tbl [13];
   ent_t mq [$];
   logic        m_wr_en, m_pc_en;
   logic [3:0]  m_wa;
   logic [31:0] m_wd, m_pd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic mv, input logic [3:0] ma, input logic [31:0] md,
                        input logic av, input logic [3:0] aa, input logic [31:0] ad);
      mem_valid_i = mv; mem_addr_i = ma; mem_data_i = md;
      alu_valid_i = av; alu_addr_i = aa; alu_data_i = ad;
   endtask

   // Reference model: one clock of the writeback rules over a plain queue.
   task automatic model_clock();
      ent_t it;
      logic have, pushed;
      pushed = alu_valid_i && (mq.size() != DEPTH);
      have = 1'b1;
      if (mem_valid_i) begin
         it.a = mem_addr_i; it.d = mem_data_i;
      end else if (mq.size() > 0) begin
         it = mq.pop_front();
      end else if (pushed) begin
         it.a = alu_addr_i; it.d = alu_data_i; pushed = 1'b0;
      end else begin
         have = 1'b0;
      end
      if (pushed) mq.push_back('{a: alu_addr_i, d: alu_data_i});
      m_wr_en = 1'b0;
      m_pc_en = 1'b0;
      if (have && it.a == 4'd15) begin
         m_pc_en = 1'b1; m_pd = it.d;
      end else if (have) begin
         m_wr_en = 1'b1; m_wa = it.a; m_wd = it.d;
      end
   endtask

`ifdef WB_FWD_EN
   task automatic model_fwd(input logic [3:0] a, output logic hit, output logic [31:0] d);
      hit = 1'b0; d = '0;
      if (a != 4'd15) begin
         for (int i = mq.size() - 1; i >= 0 && !hit; i--) begin
            if (mq[i].a == a) begin hit = 1'b1; d = mq[i].d; end
         end
         if (!hit && m_wr_en && m_wa == a) begin hit = 1'b1; d = m_wd; end
      end
   endtask
`endif

   initial begin
      tbl[0]  = '{1'b0,4'd0,32'h0,    1'b1,4'd3,32'hAA,   1'b1,4'd3,32'hAA,1'b1,   1'b0,32'h0,   2'd0,1'b1};
      tbl[1]  = '{1'b1,4'd4,32'h11,   1'b1,4'd5,32'h22,   1'b1,4'd4,32'h11,1'b1,   1'b0,32'h0,   2'd1,1'b1};
      tbl[2]  = '{1'b0,4'd0,32'h0,    1'b0,4'd0,32'h0,    1'b1,4'd5,32'h22,1'b1,   1'b0,32'h0,   2'd0,1'b1};
      tbl[3]  = '{1'b0,4'd0,32'h0,    1'b0,4'd0,32'h0,    1'b0,4'd5,32'h22,1'b1,   1'b0,32'h0,   2'd0,1'b1};
      tbl[4]  = '{1'b0,4'd0,32'h0,    1'b1,4'd15,32'h100, 1'b0,4'd0,32'h0,1'b0,    1'b1,32'h100, 2'd0,1'b1};
      tbl[5]  = '{1'b0,4'd0,32'h0,    1'b0,4'd0,32'h0,    1'b0,4'd0,32'h0,1'b0,    1'b0,32'h0,   2'd0,1'b1};
      tbl[6]  = '{1'b1,4'd1,32'h1001, 1'b1,4'd7,32'h2001, 1'b1,4'd1,32'h1001,1'b1, 1'b0,32'h0,   2'd1,1'b1};
      tbl[7]  = '{1'b1,4'd2,32'h1002, 1'b1,4'd8,32'h2002, 1'b1,4'd2,32'h1002,1'b1, 1'b0,32'h0,   2'd2,1'b0};
      tbl[8]  = '{1'b1,4'd3,32'h1003, 1'b1,4'd9,32'h2003, 1'b1,4'd3,32'h1003,1'b1, 1'b0,32'h0,   2'd2,1'b0};
      tbl[9]  = '{1'b1,4'd4,32'h1004, 1'b1,4'd10,32'h2004,1'b1,4'd4,32'h1004,1'b1, 1'b0,32'h0,   2'd2,1'b0};
      tbl[10] = '{1'b0,4'd0,32'h0,    1'b1,4'd11,32'h2005,1'b1,4'd7,32'h2001,1'b1, 1'b0,32'h0,   2'd1,1'b1};
      tbl[11] = '{1'b0,4'd0,32'h0,    1'b0,4'd0,32'h0,    1'b1,4'd8,32'h2002,1'b1, 1'b0,32'h0,   2'd0,1'b1};
      tbl[12] = '{1'b0,4'd0,32'h0,    1'b0,4'd0,32'h0,    1'b0,4'd8,32'h2002,1'b1, 1'b0,32'h0,   2'd0,1'b1};

      rst_i = 1'b1;
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
`ifdef WB_FWD_EN
      q1_addr_i = 4'd0; q2_addr_i = 4'd0;
`endif
      #2;
      chk("reset wr_en", 32'(wr_en_o), 32'h0);
      chk("reset wr_addr", 32'(wr_addr_o), 32'h0);
      chk("reset wr_data", wr_data_o, 32'h0);
      chk("reset pc_en", 32'(pc_wr_en_o), 32'h0);
      chk("reset pc_data", pc_wr_data_o, 32'h0);
      chk("reset pending", 32'(pending_o), 32'h0);
      chk("reset ready", 32'(alu_ready_o), 32'h1);
      step(); step();
      #3 rst_i = 1'b0;
      step();

      // Directed vector table: uncontended, collision, PC write, back-pressure.
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].mv, tbl[i].ma, tbl[i].md, tbl[i].av, tbl[i].aa, tbl[i].ad);
         step();
         chk($sformatf("vec%0d wr_en", i), 32'(wr_en_o), 32'(tbl[i].wr_en));
         chk($sformatf("vec%0d pc_en", i), 32'(pc_wr_en_o), 32'(tbl[i].pc_en));
         chk($sformatf("vec%0d pending", i), 32'(pending_o), 32'(tbl[i].pend));
         chk($sformatf("vec%0d ready", i), 32'(alu_ready_o), 32'(tbl[i].rdy));
         if (tbl[i].chk_wd) begin
            chk($sformatf("vec%0d wr_addr", i), 32'(wr_addr_o), 32'(tbl[i].wa));
            chk($sformatf("vec%0d wr_data", i), wr_data_o, tbl[i].wd);
         end
         if (tbl[i].pc_en) chk($sformatf("vec%0d pc_data", i), pc_wr_data_o, tbl[i].pd);
      end

      // Reset mid-operation with two buffered entries.
      drive(1'b1, 4'd1, 32'h31, 1'b1, 4'd2, 32'h32); step();
      drive(1'b1, 4'd3, 32'h33, 1'b1, 4'd4, 32'h34); step();
      chk("pre-reset pending", 32'(pending_o), 32'h2);
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      #2 rst_i = 1'b1;
      #1;
      chk("async reset wr_en", 32'(wr_en_o), 32'h0);
      chk("async reset pending", 32'(pending_o), 32'h0);
      chk("async reset ready", 32'(alu_ready_o), 32'h1);
      #2 rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("post-reset%0d wr_en", i), 32'(wr_en_o), 32'h0);
         chk($sformatf("post-reset%0d pc_en", i), 32'(pc_wr_en_o), 32'h0);
         chk($sformatf("post-reset%0d pending", i), 32'(pending_o), 32'h0);
      end

`ifdef WB_FWD_EN
      // Two r6 entries buffered behind loads; youngest must win.
      drive(1'b1, 4'd1, 32'h51, 1'b1, 4'd6, 32'h1); step();
      drive(1'b1, 4'd2, 32'h52, 1'b1, 4'd6, 32'h2); step();
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      q1_addr_i = 4'd6; q2_addr_i = 4'd15; #1;
      chk("fwd q1 hit", 32'(q1_hit_o), 32'h1);
      chk("fwd q1 data", q1_data_o, 32'h2);
      chk("fwd q2 r15 hit", 32'(q2_hit_o), 32'h0);
      chk("fwd q2 r15 data", q2_data_o, 32'h0);
      q2_addr_i = 4'd2; #1;
      chk("fwd q2 outreg hit", 32'(q2_hit_o), 32'h1);
      chk("fwd q2 outreg data", q2_data_o, 32'h52);
`endif

      // Random traffic against the queue model, starting from reset.
      rst_i = 1'b1; #2 rst_i = 1'b0;
      mq.delete();
      m_wr_en = 1'b0; m_pc_en = 1'b0; m_wa = '0; m_wd = '0; m_pd = '0;
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 9) < 3), 4'($urandom), $urandom,
               ($urandom_range(0, 9) < 6), 4'($urandom), $urandom);
`ifdef WB_FWD_EN
         begin
            logic h; logic [31:0] d;
            q1_addr_i = 4'($urandom); q2_addr_i = 4'($urandom); #1;
            model_fwd(q1_addr_i, h, d);
            chk("rand q1 hit", 32'(q1_hit_o), 32'(h));
            chk("rand q1 data", q1_data_o, d);
            model_fwd(q2_addr_i, h, d);
            chk("rand q2 hit", 32'(q2_hit_o), 32'(h));
            chk("rand q2 data", q2_data_o, d);
         end
`endif
         model_clock();
         step();
         chk("rand wr_en", 32'(wr_en_o), 32'(m_wr_en));
         chk("rand wr_addr", 32'(wr_addr_o), 32'(m_wa));
         chk("rand wr_data", wr_data_o, m_wd);
         chk("rand pc_en", 32'(pc_wr_en_o), 32'(m_pc_en));
         chk("rand pc_data", pc_wr_data_o, m_pd);
         chk("rand pending", 32'(pending_o), 32'(mq.size()));
         chk("rand ready", 32'(alu_ready_o), 32'(mq.size() != DEPTH));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
